// File: rtl/gpr_rename_map_pkg.sv
// Shared sizing for the GPR rename map and its checkpoint bank.
// Defaults mirror the core's ROB and arch register file widths.
package gpr_rename_map_pkg;

    localparam int DEF_NUM_ARCH = 32;
    localparam int DEF_ROB_SIZE = 64;
    localparam int RENAME_TW    = $clog2(DEF_ROB_SIZE);

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpr_rename_map_ckpt.sv
// Checkpoint slot array for the rename map (built with RENAME_CKPT_EN).
// Slots track commit releases so a restore never revives retired producers.
`ifdef RENAME_CKPT_EN
module rename_ckpt_bank
    import gpr_rename_map_pkg::*;
#(
    parameter int NUM_ARCH = DEF_NUM_ARCH,
    parameter int NUM_CKPT = 4,
    parameter int NUM_CMT  = 2,
    parameter int AW       = 5,
    parameter int TW       = RENAME_TW,
    parameter int CW       = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               save,
    input  logic [CW-1:0]                      sid,
    input  logic [CW-1:0]                      rid,
    input  logic [NUM_CMT-1:0]                 cmt_en,
    input  logic [NUM_CMT*AW-1:0]              cmt_addr,
    input  logic [NUM_CMT*TW-1:0]              cmt_num,
    input  logic [NUM_ARCH-1:0]                map_busy_d,
    input  logic [NUM_ARCH-1:0][TW-1:0]        map_tag_d,
    output logic [NUM_ARCH-1:0]                rd_busy,
    output logic [NUM_ARCH-1:0][TW-1:0]        rd_tag
);

    logic [NUM_CKPT-1:0][NUM_ARCH-1:0]         sb_q, sb_d;
    logic [NUM_CKPT-1:0][NUM_ARCH-1:0][TW-1:0] st_q, st_d;

    // Apply commit releases to every slot, then overwrite the saved slot
    always_comb begin
        sb_d = sb_q;
        st_d = st_q;
        for (int s = 0; s < NUM_CKPT; s++) begin
            for (int r = 0; r < NUM_ARCH; r++) begin
                for (int j = 0; j < NUM_CMT; j++) begin
                    if (cmt_en[j] &&
                        cmt_addr[j*AW +: AW] == AW'(r) &&
                        cmt_num[j*TW +: TW] == st_q[s][r])
                        sb_d[s][r] = 1'b0;
                end
            end
        end
        if (save) begin
            sb_d[sid] = map_busy_d;
            st_d[sid] = map_tag_d;
        end
    end

    // Slot storage register
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q <= '0;
            st_q <= '0;
        end else begin
            sb_q <= sb_d;
            st_q <= st_d;
        end
    end

    assign rd_busy = sb_q[rid];
    assign rd_tag  = st_q[rid];

endmodule
`endif

// File: rtl/gpr_rename_map.sv
// GPR rename/busy map: per-reg busy bit and youngest producer ROB tag.
// Branch checkpoints are built only when RENAME_CKPT_EN is defined.
module gpr_rename_map
    import gpr_rename_map_pkg::*;
#(
    parameter int NUM_ARCH = DEF_NUM_ARCH,
    parameter int ROB_SIZE = DEF_ROB_SIZE,
    parameter int NUM_RD   = 4,
    parameter int NUM_WR   = 2,
    parameter int NUM_CMT  = 2,
    parameter int NUM_CKPT = 4,
    localparam int AW      = clog2_min1(NUM_ARCH),
    localparam int TW      = clog2_min1(ROB_SIZE),
    localparam int CW      = clog2_min1(NUM_CKPT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [NUM_RD*AW-1:0]  raddr,
    output logic [NUM_RD*TW-1:0]  rnum,
    output logic [NUM_RD-1:0]     rbusy,
    input  logic [NUM_WR-1:0]     wen,
    input  logic [NUM_WR*AW-1:0]  waddr,
    input  logic [NUM_WR*TW-1:0]  wnum,
    input  logic [NUM_CMT-1:0]    cmt_en,
    input  logic [NUM_CMT*AW-1:0] cmt_addr,
    input  logic [NUM_CMT*TW-1:0] cmt_num,
    input  logic                  ckpt_save,
    input  logic [CW-1:0]         ckpt_sid,
    input  logic                  ckpt_restore,
    input  logic [CW-1:0]         ckpt_rid
);

    logic [NUM_ARCH-1:0]         busy_q, busy_d;
    logic [NUM_ARCH-1:0][TW-1:0] tag_q, tag_d;
    logic [NUM_ARCH-1:0]         base_busy;
    logic [NUM_ARCH-1:0][TW-1:0] base_tag;
    logic                        restore;

`ifdef RENAME_CKPT_EN
    logic [NUM_ARCH-1:0]         slot_busy;
    logic [NUM_ARCH-1:0][TW-1:0] slot_tag;

    assign restore   = ckpt_restore;
    assign base_busy = restore ? slot_busy : busy_q;
    assign base_tag  = restore ? slot_tag  : tag_q;

    rename_ckpt_bank #(
        .NUM_ARCH (NUM_ARCH),
        .NUM_CKPT (NUM_CKPT),
        .NUM_CMT  (NUM_CMT),
        .AW       (AW),
        .TW       (TW),
        .CW       (CW)
    ) u_ckpt (
        .clk        (clk),
        .reset      (reset),
        .save       (ckpt_save),
        .sid        (ckpt_sid),
        .rid        (ckpt_rid),
        .cmt_en     (cmt_en),
        .cmt_addr   (cmt_addr),
        .cmt_num    (cmt_num),
        .map_busy_d (busy_d),
        .map_tag_d  (tag_d),
        .rd_busy    (slot_busy),
        .rd_tag     (slot_tag)
    );
`else
    wire unused_ckpt = ^{ckpt_save, ckpt_sid, ckpt_restore, ckpt_rid};

    assign restore   = 1'b0;
    assign base_busy = busy_q;
    assign base_tag  = tag_q;
`endif

    // Next map: commit release, then rename writes, then flush on top
    always_comb begin
        busy_d = base_busy;
        tag_d  = base_tag;
        for (int r = 0; r < NUM_ARCH; r++) begin
            for (int j = 0; j < NUM_CMT; j++) begin
                if (cmt_en[j] &&
                    cmt_addr[j*AW +: AW] == AW'(r) &&
                    cmt_num[j*TW +: TW] == base_tag[r])
                    busy_d[r] = 1'b0;
            end
            if (!restore) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wen[k] && waddr[k*AW +: AW] == AW'(r)) begin
                        busy_d[r] = 1'b1;
                        tag_d[r]  = wnum[k*TW +: TW];
                    end
                end
            end
        end
        if (flush)
            busy_d = '0;
        busy_d[0] = 1'b0;
        tag_d[0]  = '0;
    end

    // Map state register
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            tag_q  <= '0;
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    // Zero-latency read ports off the registered map
    always_comb begin
        rbusy = '0;
        rnum  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rbusy[k]          = busy_q[raddr[k*AW +: AW]];
            rnum[k*TW +: TW]  = tag_q[raddr[k*AW +: AW]];
        end
    end

endmodule

// File: tb/tb_gpr_rename_map.sv
// Bench for gpr_rename_map: reset sweep, vector table, scoreboard queue.
// Checkpoint vectors are included when RENAME_CKPT_EN is defined.
module tb_gpr_rename_map;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [19:0] raddr;
    logic [23:0] rnum;
    logic [3:0]  rbusy;
    logic [1:0]  wen;
    logic [9:0]  waddr;
    logic [11:0] wnum;
    logic [1:0]  cmt_en;
    logic [9:0]  cmt_addr;
    logic [11:0] cmt_num;
    logic        ckpt_save, ckpt_restore;
    logic [1:0]  ckpt_sid, ckpt_rid;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       fl;
        logic [1:0] wen;
        logic [4:0] wa0;
        logic [5:0] wn0;
        logic [4:0] wa1;
        logic [5:0] wn1;
        logic [1:0] ce;
        logic [4:0] ca0;
        logic [5:0] cn0;
        logic [4:0] ca1;
        logic [5:0] cn1;
        logic       sv;
        logic [1:0] sid;
        logic       rs;
        logic [1:0] rid;
        logic [4:0] ra;
        logic       eb;
        logic [5:0] en;
        logic       cn;
    } vec_t;

    typedef struct {
        string      name;
        int         port;
        logic       busy;
        logic [5:0] num;
        logic       cn;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    gpr_rename_map dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .raddr        (raddr),
        .rnum         (rnum),
        .rbusy        (rbusy),
        .wen          (wen),
        .waddr        (waddr),
        .wnum         (wnum),
        .cmt_en       (cmt_en),
        .cmt_addr     (cmt_addr),
        .cmt_num      (cmt_num),
        .ckpt_save    (ckpt_save),
        .ckpt_sid     (ckpt_sid),
        .ckpt_restore (ckpt_restore),
        .ckpt_rid     (ckpt_rid)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        reset        = 1'b0;
        flush        = 1'b0;
        wen          = '0;
        waddr        = '0;
        wnum         = '0;
        cmt_en       = '0;
        cmt_addr     = '0;
        cmt_num      = '0;
        ckpt_save    = 1'b0;
        ckpt_sid     = '0;
        ckpt_restore = 1'b0;
        ckpt_rid     = '0;
    endtask

    task automatic check_one();
        exp_t       e;
        logic       gb;
        logic [5:0] gn;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        e  = exp_q.pop_front();
        gb = rbusy[e.port];
        gn = rnum[e.port*6 +: 6];
        if (gb !== e.busy || (e.cn && gn !== e.num)) begin
            n_bad++;
            $display("FAIL %s: port %0d got busy=%b num=%0d, want busy=%b num=%0d",
                     e.name, e.port, gb, gn, e.busy, e.num);
        end
    endtask

    task automatic apply(input vec_t v, input int port);
        @(negedge clk);
        reset        = v.rst;
        flush        = v.fl;
        wen          = v.wen;
        waddr        = {v.wa1, v.wa0};
        wnum         = {v.wn1, v.wn0};
        cmt_en       = v.ce;
        cmt_addr     = {v.ca1, v.ca0};
        cmt_num      = {v.cn1, v.cn0};
        ckpt_save    = v.sv;
        ckpt_sid     = v.sid;
        ckpt_restore = v.rs;
        ckpt_rid     = v.rid;
        raddr        = '0;
        raddr[port*5 +: 5] = v.ra;
        exp_q.push_back('{v.name, port, v.eb, v.en, v.cn});
        @(posedge clk);
        #1;
        idle_inputs();
        check_one();
    endtask

    initial begin
        // name, rst, fl, wen, wa0, wn0, wa1, wn1,
        // ce, ca0, cn0, ca1, cn1, sv, sid, rs, rid, ra, eb, en, cn
        tbl.push_back('{"dual_wr_r5", 1'b0, 1'b0, 2'b11, 5'd5, 6'd7, 5'd5, 6'd9,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd5, 1'b1, 6'd9, 1'b1});
        tbl.push_back('{"cmt_stale_r5", 1'b0, 1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0,
            2'b01, 5'd5, 6'd7, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd5, 1'b1, 6'd9, 1'b1});
        tbl.push_back('{"cmt_match_r5", 1'b0, 1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0,
            2'b10, 5'd0, 6'd0, 5'd5, 6'd9, 1'b0, 2'd0, 1'b0, 2'd0, 5'd5, 1'b0, 6'd9, 1'b1});
        tbl.push_back('{"wr_r3_t4", 1'b0, 1'b0, 2'b01, 5'd3, 6'd4, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd3, 1'b1, 6'd4, 1'b1});
        tbl.push_back('{"wr_beats_cmt", 1'b0, 1'b0, 2'b01, 5'd3, 6'd12, 5'd0, 6'd0,
            2'b01, 5'd3, 6'd4, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd3, 1'b1, 6'd12, 1'b1});
        tbl.push_back('{"wr_r8_t2", 1'b0, 1'b0, 2'b01, 5'd8, 6'd2, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd8, 1'b1, 6'd2, 1'b1});
        tbl.push_back('{"flush_r8", 1'b0, 1'b1, 2'b01, 5'd9, 6'd3, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd8, 1'b0, 6'd2, 1'b1});
        tbl.push_back('{"flush_r9", 1'b0, 1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd9, 1'b0, 6'd0, 1'b0});
        tbl.push_back('{"wr_r0", 1'b0, 1'b0, 2'b11, 5'd0, 6'd5, 5'd0, 6'd6,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd0, 1'b0, 6'd0, 1'b1});
        tbl.push_back('{"wr_r10_r11", 1'b0, 1'b0, 2'b11, 5'd11, 6'd21, 5'd10, 6'd20,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd10, 1'b1, 6'd20, 1'b1});
        tbl.push_back('{"rd_r11", 1'b0, 1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd11, 1'b1, 6'd21, 1'b1});
        tbl.push_back('{"cmt_dual_r10", 1'b0, 1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0,
            2'b11, 5'd10, 6'd20, 5'd11, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd10, 1'b0, 6'd20, 1'b1});
        tbl.push_back('{"cmt_dual_r11", 1'b0, 1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd11, 1'b1, 6'd21, 1'b1});
        tbl.push_back('{"wr_r31_max", 1'b0, 1'b0, 2'b01, 5'd31, 6'd63, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd31, 1'b1, 6'd63, 1'b1});
        tbl.push_back('{"wr_r31_r30", 1'b0, 1'b0, 2'b11, 5'd31, 6'd62, 5'd30, 6'd1,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd31, 1'b1, 6'd62, 1'b1});
        tbl.push_back('{"rd_r30", 1'b0, 1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd30, 1'b1, 6'd1, 1'b1});
`ifdef RENAME_CKPT_EN
        tbl.push_back('{"ck_wr_r4", 1'b0, 1'b0, 2'b01, 5'd4, 6'd1, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd4, 1'b1, 6'd1, 1'b1});
        tbl.push_back('{"ck_save2", 1'b0, 1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b1, 2'd2, 1'b0, 2'd0, 5'd4, 1'b1, 6'd1, 1'b1});
        tbl.push_back('{"ck_wr_r4_t6", 1'b0, 1'b0, 2'b01, 5'd4, 6'd6, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd4, 1'b1, 6'd6, 1'b1});
        tbl.push_back('{"ck_cmt_t1", 1'b0, 1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0,
            2'b01, 5'd4, 6'd1, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd4, 1'b1, 6'd6, 1'b1});
        tbl.push_back('{"ck_restore2", 1'b0, 1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b1, 2'd2, 5'd4, 1'b0, 6'd1, 1'b1});
        tbl.push_back('{"ck_wr_dropped", 1'b0, 1'b0, 2'b01, 5'd20, 6'd7, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b1, 2'd2, 5'd20, 1'b0, 6'd0, 1'b0});
        tbl.push_back('{"ck_wr_r21", 1'b0, 1'b0, 2'b01, 5'd21, 6'd3, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd21, 1'b1, 6'd3, 1'b1});
        tbl.push_back('{"ck_save_rest", 1'b0, 1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b1, 2'd1, 1'b1, 2'd2, 5'd21, 1'b0, 6'd0, 1'b0});
        tbl.push_back('{"ck_wr_r21_b", 1'b0, 1'b0, 2'b01, 5'd21, 6'd5, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd21, 1'b1, 6'd5, 1'b1});
        tbl.push_back('{"ck_restore1", 1'b0, 1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b1, 2'd1, 5'd21, 1'b0, 6'd0, 1'b0});
`endif
        tbl.push_back('{"rst_over_wr", 1'b1, 1'b0, 2'b01, 5'd7, 6'd3, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd7, 1'b0, 6'd0, 1'b1});
        tbl.push_back('{"post_rst_r31", 1'b0, 1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0,
            2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd31, 1'b0, 6'd0, 1'b1});

        idle_inputs();
        raddr = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int g = 0; g < 8; g++) begin
            @(negedge clk);
            for (int p = 0; p < 4; p++)
                raddr[p*5 +: 5] = 5'(g*4 + p);
            #1;
            for (int p = 0; p < 4; p++) begin
                exp_q.push_back('{"reset_map", p, 1'b0, 6'd0, 1'b1});
                check_one();
            end
        end

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i % 4);

        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
